// File: rtl/program_loader_pkg.sv
// Shared constants and types for the program loader.
//   LOADER_INST_SIZE : default instruction BRAM address width
//   LOADER_LEN_BYTES : size of the big-endian length header
//   LOADER_ACK/NAK   : completion / overflow reply bytes
//   loader_state_t   : loader control states
package program_loader_pkg;

  localparam int unsigned LOADER_INST_SIZE = 15;
  localparam int unsigned LOADER_LEN_BYTES = 4;
  localparam logic [7:0]  LOADER_ACK       = 8'hAA;
  localparam logic [7:0]  LOADER_NAK       = 8'h55;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_ACK,
    S_DONE,
    S_ERR
  } loader_state_t;

  // True when a requested word count does not fit in 2**isz words.
  function automatic logic len_overflow(input logic [31:0] n, input int unsigned isz);
    return {1'b0, n} > (33'd1 << isz);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream, reply-byte and instruction-BRAM write signals of the loader.
//   rx_data/rx_valid            : incoming UART bytes (one-cycle strobe)
//   tx_data/tx_valid/tx_ready   : reply byte handshake to the UART transmitter
//   inst_we/inst_addr/inst_wdata: instruction BRAM write port
// master = loader side, slave = UART/BRAM side.
interface program_loader_if #(
  parameter int unsigned INST_SIZE = program_loader_pkg::LOADER_INST_SIZE,
  parameter int unsigned WORD_W    = 32
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 inst_we;
  logic [INST_SIZE-1:0] inst_addr;
  logic [WORD_W-1:0]    inst_wdata;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid, inst_we, inst_addr, inst_wdata
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid, inst_we, inst_addr, inst_wdata
  );
endinterface

// File: rtl/program_loader_word_pack.sv
// Big-endian byte-to-word packer.
//   clk, rstn  : clock, async active-low reset
//   byte_valid : byte_data is consumed this cycle
//   byte_data  : incoming byte (first byte lands in the word MSBs)
//   word_valid : high in the cycle the last byte of a word is consumed
//   word       : assembled word, valid alongside word_valid
module loader_word_pack #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                word_valid,
  output logic [NBYTES*8-1:0] word
);
  localparam int unsigned W  = NBYTES * 8;
  localparam int unsigned CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  shift_q, shift_d;

  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    word_valid = 1'b0;
    if (byte_valid) begin
      shift_d = (shift_q << 8) | W'(byte_data);
      if (cnt_q == CW'(NBYTES - 1)) begin
        cnt_d      = '0;
        word_valid = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Presenting the next-state value lets the caller register the word in the
  // same edge that consumes its final byte.
  assign word = shift_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end
endmodule

// File: rtl/program_loader.sv
// Loads a program image from a UART byte stream into instruction BRAM.
// Stream: 4-byte big-endian word count N, then N big-endian words, written
// to addresses 0..N-1. Replies ACK_BYTE on success or NAK_BYTE if N exceeds
// the BRAM; done releases the core from reset.
//   clk, rstn : clock, async active-low reset
//   bus       : rx byte stream, tx reply handshake, BRAM write port
//   busy      : load in progress (after first length byte until ACK accepted)
//   done      : image written and ACK accepted
//   error     : length overflow
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned INST_SIZE = LOADER_INST_SIZE,
  parameter int unsigned WORD_W    = 32,
  parameter logic [7:0]  ACK_BYTE  = LOADER_ACK,
  parameter logic [7:0]  NAK_BYTE  = LOADER_NAK
) (
  input  logic             clk,
  input  logic             rstn,
  program_loader_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             error
);
  loader_state_t        state_q, state_d;
  logic [INST_SIZE-1:0] idx_q, idx_d;
  logic [INST_SIZE-1:0] last_q, last_d;
  logic                 inst_we_q, inst_we_d;
  logic [INST_SIZE-1:0] inst_addr_q, inst_addr_d;
  logic [WORD_W-1:0]    inst_wdata_q, inst_wdata_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic              len_valid;
  logic [31:0]       len_word;
  logic              data_valid;
  logic [WORD_W-1:0] data_word;

  loader_word_pack #(.NBYTES(LOADER_LEN_BYTES)) u_len_pack (
    .clk        (clk),
    .rstn       (rstn),
    .byte_valid (bus.rx_valid && (state_q == S_LEN)),
    .byte_data  (bus.rx_data),
    .word_valid (len_valid),
    .word       (len_word)
  );

  loader_word_pack #(.NBYTES(WORD_W / 8)) u_data_pack (
    .clk        (clk),
    .rstn       (rstn),
    .byte_valid (bus.rx_valid && (state_q == S_DATA)),
    .byte_data  (bus.rx_data),
    .word_valid (data_valid),
    .word       (data_word)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_d       = last_q;
    inst_we_d    = 1'b0;
    inst_addr_d  = inst_addr_q;
    inst_wdata_d = inst_wdata_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    case (state_q)
      S_LEN: begin
        if (bus.rx_valid) busy_d = 1'b1;
        if (len_valid) begin
          if (len_word == '0) begin
            state_d    = S_ACK;
            tx_valid_d = 1'b1;
            tx_data_d  = ACK_BYTE;
          end else if (len_overflow(len_word, INST_SIZE)) begin
            state_d    = S_ERR;
            busy_d     = 1'b0;
            error_d    = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = NAK_BYTE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
            // N <= 2**INST_SIZE, so N-1 always fits the address width.
            last_d  = INST_SIZE'(len_word - 32'd1);
          end
        end
      end
      S_DATA: begin
        // The write cycle of the final word decides the exit; a word
        // completing in that same cycle is beyond N and is not written.
        if (inst_we_q && (inst_addr_q == last_q)) begin
          state_d    = S_ACK;
          tx_valid_d = 1'b1;
          tx_data_d  = ACK_BYTE;
        end else if (data_valid) begin
          inst_we_d    = 1'b1;
          inst_addr_d  = idx_q;
          inst_wdata_d = data_word;
          idx_d        = idx_q + INST_SIZE'(1);
        end
      end
      S_ACK: begin
        if (bus.tx_ready) begin
          state_d    = S_DONE;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
      end
      S_DONE: begin
      end
      S_ERR: begin
        if (tx_valid_q && bus.tx_ready) tx_valid_d = 1'b0;
      end
      default: state_d = S_LEN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_LEN;
      idx_q        <= '0;
      last_q       <= '0;
      inst_we_q    <= 1'b0;
      inst_addr_q  <= '0;
      inst_wdata_q <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      inst_we_q    <= inst_we_d;
      inst_addr_q  <= inst_addr_d;
      inst_wdata_q <= inst_wdata_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.inst_we    = inst_we_q;
  assign bus.inst_addr  = inst_addr_q;
  assign bus.inst_wdata = inst_wdata_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_data    = tx_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  localparam logic [7:0] ACK = 8'hAA;
  localparam logic [7:0] NAK = 8'h55;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  int         sel = 0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two instances: default 15-bit BRAM, and a 3-bit one to reach the
  // full-capacity boundary within a short run.
  program_loader_if #(.INST_SIZE(15), .WORD_W(32)) if_l ();
  program_loader_if #(.INST_SIZE(3),  .WORD_W(32)) if_s ();

  logic busy_l, done_l, error_l, busy_s, done_s, error_s;

  program_loader #(.INST_SIZE(15), .WORD_W(32)) dut_l (
    .clk(clk), .rstn(rstn), .bus(if_l), .busy(busy_l), .done(done_l), .error(error_l)
  );
  program_loader #(.INST_SIZE(3), .WORD_W(32)) dut_s (
    .clk(clk), .rstn(rstn), .bus(if_s), .busy(busy_s), .done(done_s), .error(error_s)
  );

  assign if_l.rx_data  = rx_data;
  assign if_l.rx_valid = rx_valid;
  assign if_l.tx_ready = tx_ready;
  assign if_s.rx_data  = rx_data;
  assign if_s.rx_valid = rx_valid;
  assign if_s.tx_ready = tx_ready;

  logic        obs_we, obs_tx_valid, obs_busy, obs_done, obs_error;
  logic [31:0] obs_addr, obs_wdata;
  logic [7:0]  obs_tx_data;
  assign obs_we       = (sel != 0) ? if_s.inst_we    : if_l.inst_we;
  assign obs_addr     = (sel != 0) ? 32'(if_s.inst_addr) : 32'(if_l.inst_addr);
  assign obs_wdata    = (sel != 0) ? if_s.inst_wdata : if_l.inst_wdata;
  assign obs_tx_valid = (sel != 0) ? if_s.tx_valid   : if_l.tx_valid;
  assign obs_tx_data  = (sel != 0) ? if_s.tx_data    : if_l.tx_data;
  assign obs_busy     = (sel != 0) ? busy_s  : busy_l;
  assign obs_done     = (sel != 0) ? done_s  : done_l;
  assign obs_error    = (sel != 0) ? error_s : error_l;

  // Activity log, sampled on the falling edge.
  bit          log_en = 1'b0;
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [7:0]  tx_log[$];
  int          txv_cnt = 0;
  int          hs_cyc = -1;
  int          done_cyc = -1;
  logic        first_busy = 1'b0;

  always @(negedge clk) begin
    if (log_en && rstn) begin
      if (obs_we) begin
        wr_addr.push_back(int'(obs_addr));
        wr_data.push_back(obs_wdata);
        wr_cyc.push_back(cyc);
      end
      if (obs_tx_valid) begin
        if (txv_cnt == 0) first_busy = obs_busy;
        txv_cnt++;
      end
      if (obs_tx_valid && tx_ready) begin
        tx_log.push_back(obs_tx_data);
        hs_cyc = cyc;
      end
      if (obs_done && done_cyc < 0) done_cyc = cyc;
    end
  end

  logic [7:0]  bytes[$];
  int          bcyc[$];
  logic [31:0] stim_words[$];

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    bcyc.push_back(cyc);
    repeat (gap) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    rstn     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    sel      = 0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    rstn     = 1'b0;
    #2;
    checks++; if ({obs_we, obs_tx_valid, obs_busy, obs_done, obs_error} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: we/txv/busy/done/err=%b required 00000",
                         {obs_we, obs_tx_valid, obs_busy, obs_done, obs_error});
    end
    checks++; if (obs_addr !== 32'h0 || obs_wdata !== 32'h0 || obs_tx_data !== 8'h0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h tx=%h required 0", obs_addr, obs_wdata, obs_tx_data);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    step();
    checks++; if ({obs_busy, obs_done, obs_error, obs_tx_valid} !== 4'b0) begin
      errors++; $display("FAIL post_reset_idle: busy/done/err/txv=%b required 0000",
                         {obs_busy, obs_done, obs_error, obs_tx_valid});
    end
    send_byte(8'h00, 0);
    step();
    checks++; if (obs_busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_first_byte: busy=%b required 1", obs_busy);
    end
    checks++; if (obs_done !== 1'b0) begin
      errors++; $display("FAIL done_during_len: done=%b required 0", obs_done);
    end
  endtask

  // One complete load compared against a model built from the byte stream.
  task automatic test_load(input string tag, input int s, input logic [31:0] n,
                           input int nwords, input bit b2b, input int delay, input bit rst);
    int          isz;
    bit          err;
    int          exp_n;
    logic [7:0]  exp_tx;
    logic [31:0] exp_word;
    bit          found;
    int          nw_before;
    int          b;

    if (rst) do_reset();
    sel = s;
    isz = (s != 0) ? 3 : 15;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); tx_log.delete();
    txv_cnt = 0; hs_cyc = -1; done_cyc = -1;
    log_en   = 1'b1;
    tx_ready = (delay == 0);

    bytes.delete(); bcyc.delete();
    for (int k = 3; k >= 0; k--) bytes.push_back(n[k*8 +: 8]);
    for (int i = 0; i < nwords; i++) begin
      logic [31:0] w;
      w = (i < stim_words.size()) ? stim_words[i] : $urandom;
      for (int k = 3; k >= 0; k--) bytes.push_back(w[k*8 +: 8]);
    end
    stim_words.delete();
    for (int i = 0; i < bytes.size(); i++)
      send_byte(bytes[i], (i == bytes.size() - 1 || b2b) ? 0 : int'($urandom_range(0, 3)));

    err    = ({32'h0, n} > (64'd1 << isz));
    exp_n  = err ? 0 : int'(n);
    exp_tx = err ? NAK : ACK;

    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (tx_log.size() > 0 || (obs_tx_valid && delay > 0)) begin
        found = 1'b1;
        break;
      end
      step();
    end
    rx_valid = 1'b0;
    checks++; if (!found) begin
      errors++; $display("FAIL %s tx_timeout: no reply within 200 cycles, required one", tag);
    end
    if (found && delay > 0) begin
      for (int k = 0; k < delay; k++) begin
        checks++; if (obs_tx_valid !== 1'b1 || obs_tx_data !== exp_tx) begin
          errors++; $display("FAIL %s tx_hold: cycle %0d valid=%b data=%h required 1/%h",
                             tag, k, obs_tx_valid, obs_tx_data, exp_tx);
        end
        step();
      end
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
    end
    repeat (4) step();
    tx_ready = 1'b0;

    checks++; if (wr_addr.size() != exp_n) begin
      errors++; $display("FAIL %s write_count: %0d required %0d", tag, wr_addr.size(), exp_n);
    end
    for (int i = 0; i < wr_addr.size() && i < exp_n; i++) begin
      b = 4 + 4 * i;
      exp_word = {bytes[b], bytes[b+1], bytes[b+2], bytes[b+3]};
      checks++; if (wr_addr[i] != i || wr_data[i] !== exp_word) begin
        errors++; $display("FAIL %s write_%0d: addr=%0d data=%h required addr=%0d data=%h",
                           tag, i, wr_addr[i], wr_data[i], i, exp_word);
      end
      checks++; if (wr_cyc[i] != bcyc[b+3] + 1) begin
        errors++; $display("FAIL %s write_latency_%0d: cycle %0d required %0d",
                           tag, i, wr_cyc[i], bcyc[b+3] + 1);
      end
    end
    checks++; if (tx_log.size() != 1) begin
      errors++; $display("FAIL %s tx_count: %0d required 1", tag, tx_log.size());
    end
    if (tx_log.size() > 0) begin
      checks++; if (tx_log[0] !== exp_tx) begin
        errors++; $display("FAIL %s tx_byte: %h required %h", tag, tx_log[0], exp_tx);
      end
    end
    checks++; if (txv_cnt != ((delay > 0) ? delay + 1 : 1)) begin
      errors++; $display("FAIL %s tx_valid_cycles: %0d required %0d", tag, txv_cnt,
                         (delay > 0) ? delay + 1 : 1);
    end
    checks++; if (first_busy !== !err) begin
      errors++; $display("FAIL %s busy_at_reply: %b required %b", tag, first_busy, !err);
    end
    checks++; if (obs_done !== !err || obs_error !== err || obs_busy !== 1'b0 || obs_tx_valid !== 1'b0) begin
      errors++; $display("FAIL %s final_flags: done=%b err=%b busy=%b txv=%b required %b/%b/0/0",
                         tag, obs_done, obs_error, obs_busy, obs_tx_valid, !err, err);
    end
    checks++; if (done_cyc != (err ? -1 : hs_cyc + 1)) begin
      errors++; $display("FAIL %s done_timing: cycle %0d required %0d", tag, done_cyc,
                         err ? -1 : hs_cyc + 1);
    end

    // Bytes after completion must have no effect.
    nw_before = wr_addr.size();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1);
    repeat (3) step();
    checks++; if (wr_addr.size() != nw_before || tx_log.size() != 1) begin
      errors++; $display("FAIL %s ignore_extra: writes=%0d tx=%0d required %0d/1",
                         tag, wr_addr.size(), tx_log.size(), nw_before);
    end
    checks++; if (obs_done !== !err || obs_error !== err) begin
      errors++; $display("FAIL %s flags_after_extra: done=%b err=%b required %b/%b",
                         tag, obs_done, obs_error, !err, err);
    end
    log_en = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    sel = 0;
    log_en = 1'b0;
    for (int k = 0; k < 4; k++) send_byte((k == 3) ? 8'd2 : 8'd0, 0);
    for (int k = 0; k < 6; k++) send_byte(8'($urandom_range(1, 255)), 0);
    step();
    checks++; if (obs_busy !== 1'b1) begin
      errors++; $display("FAIL midload_busy: busy=%b required 1", obs_busy);
    end
    rstn = 1'b0;
    #1;
    checks++; if ({obs_we, obs_busy, obs_tx_valid, obs_done, obs_error} !== 5'b0 ||
                  obs_addr !== 32'h0 || obs_wdata !== 32'h0) begin
      errors++; $display("FAIL midload_reset_clear: flags=%b addr=%h wdata=%h required 0",
                         {obs_we, obs_busy, obs_tx_valid, obs_done, obs_error}, obs_addr, obs_wdata);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    stim_words.push_back(32'hDEADBEEF);
    test_load("reload", 0, 32'd1, 1, 1'b0, 2, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();

    stim_words = '{32'h10000001, 32'h20000002, 32'h30000003};
    test_load("three_words", 0, 32'd3, 3, 1'b0, 0, 1'b1);

    test_load("zero_len", 0, 32'd0, 0, 1'b0, 0, 1'b1);

    test_load("overflow", 0, 32'h00008001, 0, 1'b0, 0, 1'b1);

    test_load("back_to_back", 0, 32'd2, 2, 1'b1, 3, 1'b1);

    test_load("ack_stall", 0, 32'd1, 1, 1'b0, 10, 1'b1);

    test_reset_mid_load();

    test_load("full_capacity", 1, 32'd8, 8, 1'b1, 1, 1'b1);

    test_load("small_overflow", 1, 32'd9, 0, 1'b0, 2, 1'b1);

    for (int r = 0; r < 3; r++) begin
      int nw;
      nw = int'($urandom_range(1, 5));
      test_load("random", 0, 32'(nw), nw, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Receives a program image as a byte stream from the UART receiver and writes it, word by word, into instruction BRAM from address 0.
- Writes into the same memory that the core's fetch stage reads.
- Holds the core in reset (via `done` low) until the image is fully written.
- Reports completion with an ACK byte to the host through the UART transmitter handshake.

Parameters:
- INST_SIZE, 15, instruction BRAM address width; capacity is 2**INST_SIZE words.
- WORD_W, 32, instruction word width in bits; must be a multiple of 8.
- ACK_BYTE, 8'hAA, byte sent on successful load.
- NAK_BYTE, 8'h55, byte sent on length overflow.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready
- inst_we  out  1  instruction BRAM write enable
- inst_addr  out  INST_SIZE  instruction BRAM write address
- inst_wdata  out  WORD_W  instruction BRAM write data
- busy  out  1  high in S_LEN (after first byte), S_DATA and S_ACK
- done  out  1  load finished; core reset is released on done
- error  out  1  length overflow detected

Behaviour:
- Reset (async, rstn=0), all outputs 0:
  - state=S_LEN; byte counter, word index, length and word shift register cleared.
  - On reset release the block starts in S_LEN.
- Byte order: big-endian. The first byte received is bits [WORD_W-1:WORD_W-8]. The length field is always 4 bytes regardless of WORD_W.
- S_LEN:
  - Shift 4 bytes into the 32-bit length N.
  - On the 4th byte, transition on the next cycle:
    - N==0 -> S_ACK.
    - N > 2**INST_SIZE -> S_ERR.
    - otherwise -> S_DATA with word index 0.
- S_DATA:
  - Shift WORD_W/8 bytes per word.
  - The cycle after the last byte of a word: inst_we=1 for exactly one cycle, inst_addr=word index, inst_wdata=assembled word. All three outputs are registered (1-cycle latency from the final rx_valid).
  - The word index increments on the write cycle.
  - When the written index == N-1, go to S_ACK in the cycle after the write.
  - An rx_valid arriving in the same cycle as the write is accepted into the next word; no bytes are dropped at full UART rate.
- S_ACK:
  - tx_valid=1, tx_data=ACK_BYTE, held stable until tx_ready is sampled high.
  - On that cycle tx_valid drops the next cycle; go to S_DONE.
- S_DONE: done=1 held; busy=0; rx bytes ignored; inst_we stays 0.
- S_ERR:
  - error=1 held.
  - Send NAK_BYTE once with the same handshake as S_ACK, then remain in S_ERR until reset.
  - done stays 0; no BRAM writes.
- Boundaries:
  - N == 2**INST_SIZE is legal; the final write is at address 2**INST_SIZE-1 and the word index does not wrap before S_ACK.
  - tx_ready high in the first S_ACK cycle completes the handshake in one cycle.
  - Reset mid-load discards the partial word and length. BRAM contents already written are not cleared; the next load overwrites from 0.
- inst_addr and inst_wdata hold their last values when inst_we=0.

Decomposition:
- Shared constant package gets: LOADER_ACK=8'hAA, LOADER_NAK=8'h55, and a loader_state_t enum {S_LEN, S_DATA, S_ACK, S_DONE, S_ERR}. Module parameters default from these.
- INST_SIZE is taken from the package.
- One natural sub-module: loader_word_pack.
  - Shift register plus byte counter, parameterised by byte count.
  - Emits a one-cycle word_valid with the assembled word.
  - Used for both the length field (4 bytes) and instruction words.

Test Plan:
- N=3 then words 0x10000001, 0x20000002, 0x30000003 -> writes at addr 0,1,2 with those values, one inst_we pulse each one cycle after the last byte; tx_data=0xAA; done=1.
- N=0 -> no inst_we; ACK 0xAA sent; done=1 immediately after the handshake.
- N=0x00008001 (INST_SIZE=15) -> error=1, NAK 0x55 sent once, no writes, done stays 0; further bytes ignored.
- Back-to-back rx_valid every cycle for N=2 -> both words written correctly; no byte lost at the write-cycle overlap.
- tx_ready held low 10 cycles in S_ACK -> tx_valid and tx_data=0xAA stable throughout; done rises one cycle after tx_ready is sampled high.
- rstn pulsed low after 6 data bytes, then reload N=1 word 0xDEADBEEF -> single write addr 0 = 0xDEADBEEF; no stale partial-word bytes in it.
